pio_bus_arbiter: RTL and testbench
==================================

# pio_bus_arbiter

Shares one `pio_inout` Avalon-MM slave between `N_REQ` internal requesters, such as a firmware bridge and a hardware sequencer. Requesters are granted in round-robin order. Each granted command becomes exactly one Avalon-MM read or write cycle, and the result goes back to the granted requester. A requester may hold a lock across several commands, so multi-step sequences (set direction, then drive data) cannot be interleaved with other requesters.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters (2..8).
- `ADDR_W`, 3: Avalon address width.
- `DATA_W`, 32: Avalon data width.
- `READ_LATENCY`, 1: fixed slave read latency in cycles (≥1). `readdata` is valid this many cycles after the `read` cycle.
- `LOCK_TIMEOUT`, 64: number of idle cycles after which an unused lock is dropped (≥1).

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester command valid.
- `req_write`  in  N_REQ  1 = write, 0 = read.
- `req_lock`  in  N_REQ  keep the grant after the current command.
- `req_addr`  in  N_REQ*ADDR_W  flattened; requester i at `[i*ADDR_W +: ADDR_W]`.
- `req_wdata`  in  N_REQ*DATA_W  flattened, same packing.
- `req_ready`  out  N_REQ  one-hot accept pulse.
- `rsp_valid`  out  N_REQ  one-hot completion pulse.
- `rsp_rdata`  out  DATA_W  read data; meaningful only with `rsp_valid` for a read.
- `avm_address`  out  ADDR_W  to the slave `address`.
- `avm_write`  out  1  to the slave `write`.
- `avm_read`  out  1  to the slave `read`.
- `avm_writedata`  out  DATA_W  to the slave `writedata`.
- `avm_readdata`  in  DATA_W  from the slave `readdata`.

## Operation
- FSM states: IDLE, ISSUE, RD_WAIT, LOCKED.
- **IDLE:**
  - Candidates are all requesters with `req_valid`.
  - The winner is the first candidate at or after `rr_ptr`, searching upward and wrapping at `N_REQ`.
  - The winner gets `req_ready` for that cycle. Its addr/wdata/write are latched, `owner` is recorded, `rr_ptr` becomes winner+1 mod N_REQ, and the FSM moves to ISSUE.
  - With no candidate, stay in IDLE.
- **ISSUE:**
  - Drive `avm_address`/`avm_writedata` from the latched command and assert `avm_write` or `avm_read` for exactly one cycle. The slave has no waitrequest.
  - Write: register `rsp_valid[owner]`, then go to the done-transition.
  - Read: load the latency counter with `READ_LATENCY` and go to RD_WAIT.
- **RD_WAIT:**
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture `avm_readdata` into `rsp_rdata`, register `rsp_valid[owner]`, then go to the done-transition.
- **Done-transition:**
  - If `req_lock[owner]` is high in the completion cycle, go to LOCKED with the idle counter cleared.
  - Otherwise go to IDLE.
- **LOCKED:**
  - Only `owner` is eligible. On `req_valid[owner]`: assert `req_ready[owner]`, latch the command, go to ISSUE. `rr_ptr` is unchanged.
  - Drop the lock and go to IDLE if `req_lock[owner]` deasserts, or if the idle counter reaches `LOCK_TIMEOUT` with no `req_valid[owner]`.
  - The idle counter increments each cycle without a command and clears on each accepted command.
- `req_valid` must be held until `req_ready`. A requester deasserting `req_valid` before acceptance is legal and loses nothing.
- At most one Avalon command is outstanding at any time.
- Addresses pass through unchecked; the slave ignores undecoded addresses.

## Timing
- Reset value of every output is 0. `rr_ptr` resets to 0, the FSM to IDLE, `owner` to 0, and all counters to 0.
- Reset mid-operation abandons the transaction with no `rsp_valid`. An Avalon cycle already issued is not retried.
- Accept at cycle T (`req_ready`). Avalon strobe at T+1.
- Write: `rsp_valid` at T+2.
- Read: data captured at T+1+READ_LATENCY; `rsp_valid` and `rsp_rdata` at T+2+READ_LATENCY (T+3 for the default).
- Back-to-back commands: next accept no earlier than the cycle `rsp_valid` is high. Throughput is 1 command per 2 cycles for writes and per 2+READ_LATENCY cycles for reads.
- `rsp_rdata` holds its value until the next read completes.
- Simultaneous requests in IDLE: the round-robin rule decides, with no fixed priority after reset.

## Structure
- Shared package `pio_pkg`:
  - `PIO_ADDR_DIR` = 3'd0 and `PIO_ADDR_DATA` = 3'd1.
  - FSM state typedef.
  - `PIO_DIR_OUT` = 1, `PIO_DIR_IN` = 0.
- Sub-module `pio_rr_arbiter`:
  - Parameterised by `N_REQ`.
  - Inputs: request vector and `rr_ptr`. Outputs: one-hot grant and winner index.
  - Purely combinational; the pointer register stays in the parent.

## Test plan
- Reset, then requester 0 writes addr 0 data 1 → `req_ready[0]` at T, `avm_write`=1 with address 0 and writedata 1 at T+1, `rsp_valid`=01 at T+2. The PIO pin becomes an output.
- Requester 1 reads addr 1 while the slave returns 32'h1 → `avm_read` at T+1, `rsp_valid`=10 with `rsp_rdata`=32'h1 at T+3.
- Both requesters hold `req_valid` continuously with writes → grants alternate 0,1,0,1; every Avalon strobe is single-cycle.
- Requester 0 with `req_lock`=1 issues two writes while requester 1 is requesting → both requester-0 writes complete before `req_ready[1]`. Dropping the lock grants requester 1 on the next IDLE cycle.
- Requester 0 takes the lock, then goes silent for `LOCK_TIMEOUT`=64 cycles → the FSM returns to IDLE on cycle 64 and requester 1 is granted next.
- Assert `reset` in RD_WAIT → all outputs 0 the next cycle, no `rsp_valid`. A new request after reset is granted to requester 0 first.

Source files
------------

// File: rtl/pio_bus_arbiter_pkg.sv
// rtl/pio_bus_arbiter_pkg.sv - shared constants and FSM state type for the PIO bus arbiter
package pio_pkg;

  localparam logic [2:0] PIO_ADDR_DIR  = 3'd0;
  localparam logic [2:0] PIO_ADDR_DATA = 3'd1;

  localparam logic PIO_DIR_OUT = 1'b1;
  localparam logic PIO_DIR_IN  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_LOCKED  = 2'd3
  } pio_state_t;

endpackage

// File: rtl/pio_bus_arbiter_if.sv
// rtl/pio_bus_arbiter_if.sv - requester command/response and Avalon-MM signal bundle
interface pio_bus_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_write;
  logic [N_REQ-1:0]        req_lock;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_rdata;
  logic [ADDR_W-1:0]       avm_address;
  logic                    avm_write;
  logic                    avm_read;
  logic [DATA_W-1:0]       avm_writedata;
  logic [DATA_W-1:0]       avm_readdata;

  // arbiter side
  modport slave (
    input  req_valid, req_write, req_lock, req_addr, req_wdata, avm_readdata,
    output req_ready, rsp_valid, rsp_rdata, avm_address, avm_write, avm_read, avm_writedata
  );

  // requesters plus the PIO slave, seen from outside the arbiter
  modport master (
    output req_valid, req_write, req_lock, req_addr, req_wdata, avm_readdata,
    input  req_ready, rsp_valid, rsp_rdata, avm_address, avm_write, avm_read, avm_writedata
  );

endinterface

// File: rtl/pio_rr_arbiter.sv
// rtl/pio_rr_arbiter.sv - combinational round-robin pick starting at rr_ptr
module pio_rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] winner
);

  // Scan from farthest to nearest so the candidate closest at/after rr_ptr is written last.
  always_comb begin
    grant  = '0;
    winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % N_REQ]) begin
        winner = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
    if (|req) begin
      grant[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/pio_bus_arbiter.sv
// rtl/pio_bus_arbiter.sv - round-robin sharing of one PIO Avalon-MM slave with lockable grants
module pio_bus_arbiter
  import pio_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int ADDR_W       = 3,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int LOCK_TIMEOUT = 64
) (
  input logic                clk,
  input logic                reset,
  pio_bus_arbiter_if.slave   bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(READ_LATENCY + 1);
  localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);

  pio_state_t        state, state_nxt;
  logic [IDX_W-1:0]  rr_ptr, owner, winner, accept_idx;
  logic [N_REQ-1:0]  grant, rsp_q;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata, rdata_q;
  logic              cmd_write;
  logic [CNT_W-1:0]  lat_cnt;
  logic [TO_W-1:0]   idle_cnt;
  logic              accept, done, capture;

  pio_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr),
    .grant  (grant),
    .winner (winner)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state, accept decision and completion detection.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    accept_idx = owner;
    done       = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|grant) begin
          accept     = 1'b1;
          accept_idx = winner;
          state_nxt  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_write) done = 1'b1;
        else           state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // Counter is about to reach zero: readdata is valid this cycle.
        if (lat_cnt == CNT_W'(1)) begin
          done    = 1'b1;
          capture = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (bus.req_valid[owner]) begin
          accept    = 1'b1;
          state_nxt = ST_ISSUE;
        end else if (!bus.req_lock[owner] || idle_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (done) state_nxt = bus.req_lock[owner] ? ST_LOCKED : ST_IDLE;
  end

  // Output decode; req_ready is suppressed while reset is held so outputs read 0.
  always_comb begin
    bus.req_ready = '0;
    if (accept && !reset) bus.req_ready[accept_idx] = 1'b1;
    bus.avm_write     = (state == ST_ISSUE) && cmd_write;
    bus.avm_read      = (state == ST_ISSUE) && !cmd_write;
    bus.avm_address   = cmd_addr;
    bus.avm_writedata = cmd_wdata;
    bus.rsp_valid     = rsp_q;
    bus.rsp_rdata     = rdata_q;
  end

  // Command latch, pointers, counters and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      owner     <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_write <= 1'b0;
      lat_cnt   <= '0;
      idle_cnt  <= '0;
      rsp_q     <= '0;
      rdata_q   <= '0;
    end else begin
      rsp_q <= '0;
      if (accept) begin
        owner     <= accept_idx;
        cmd_write <= bus.req_write[accept_idx];
        cmd_addr  <= bus.req_addr[accept_idx*ADDR_W +: ADDR_W];
        cmd_wdata <= bus.req_wdata[accept_idx*DATA_W +: DATA_W];
      end
      // Only fresh arbitration moves the pointer; locked commands leave it alone.
      if (state == ST_IDLE && accept) begin
        rr_ptr <= (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);
      end
      if (state == ST_ISSUE)        lat_cnt <= CNT_W'(READ_LATENCY);
      else if (state == ST_RD_WAIT) lat_cnt <= lat_cnt - CNT_W'(1);
      if (done)    rsp_q[owner] <= 1'b1;
      if (capture) rdata_q      <= bus.avm_readdata;
      if (state != ST_LOCKED || accept) idle_cnt <= '0;
      else                              idle_cnt <= idle_cnt + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_pio_bus_arbiter.sv
// tb/tb_pio_bus_arbiter.sv - directed and randomized self-checking bench for pio_bus_arbiter
module tb_pio_bus_arbiter;
  import pio_pkg::*;

  localparam int N_REQ  = 2;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;
  localparam int RL     = 1;
  localparam int LT     = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pio_bus_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pio_bus_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .READ_LATENCY(RL), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // PIO slave: 8 registers reset to their own index, one-cycle read latency.
  logic [DATA_W-1:0] slave_mem [8];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) slave_mem[i] <= DATA_W'(i);
      bus.avm_readdata <= '0;
    end else begin
      if (bus.avm_write) slave_mem[bus.avm_address] <= bus.avm_writedata;
      if (bus.avm_read)  bus.avm_readdata <= slave_mem[bus.avm_address];
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic l,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_valid[i] = v;
    bus.req_write[i] = w;
    bus.req_lock[i]  = l;
    bus.req_addr[i*ADDR_W +: ADDR_W]  = a;
    bus.req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, bus.req_ready, 0);
    chk({tag, "_rsp"}, bus.rsp_valid, 0);
    chk({tag, "_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "_strobes"}, {bus.avm_write, bus.avm_read}, 0);
    chk({tag, "_addr"}, bus.avm_address, 0);
    chk({tag, "_wdata"}, bus.avm_writedata, 0);
  endtask

  // Reference model state for the randomized phase.
  logic [DATA_W-1:0] model_mem [8];
  int free_cyc, ptr, st_cyc, rs_cyc, rs_who, w, got;
  logic st_wr, rs_rd;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data, rs_data, last_rd;
  logic [N_REQ-1:0] exp_rdy, acc_obs;

  initial begin
    clear_reqs();
    reset = 1'b1;
    repeat (3) cycle();
    #1;
    chk_all_zero("reset");

    // Write DIR=OUT from requester 0.
    cycle(); reset = 1'b0; set_req(0, 1, 1, 0, PIO_ADDR_DIR, DATA_W'(PIO_DIR_OUT)); #1;
    chk("t1_ready", bus.req_ready, 2'b01);
    cycle(); set_req(0, 0, 0, 0, 0, 0); #1;
    chk("t1_strobes", {bus.avm_write, bus.avm_read}, 2'b10);
    chk("t1_addr", bus.avm_address, PIO_ADDR_DIR);
    chk("t1_wdata", bus.avm_writedata, 1);
    chk("t1_rsp_early", bus.rsp_valid, 0);
    cycle(); #1;
    chk("t1_rsp", bus.rsp_valid, 2'b01);
    chk("t1_dir_out", slave_mem[PIO_ADDR_DIR], DATA_W'(PIO_DIR_OUT));

    // Read DATA from requester 1.
    cycle(); set_req(1, 1, 0, 0, PIO_ADDR_DATA, 0); #1;
    chk("t2_ready", bus.req_ready, 2'b10);
    cycle(); set_req(1, 0, 0, 0, 0, 0); #1;
    chk("t2_strobes", {bus.avm_write, bus.avm_read}, 2'b01);
    chk("t2_addr", bus.avm_address, PIO_ADDR_DATA);
    cycle(); #1;
    chk("t2_rsp_early", bus.rsp_valid, 0);
    cycle(); #1;
    chk("t2_rsp", bus.rsp_valid, 2'b10);
    chk("t2_rdata", bus.rsp_rdata, 32'h1);

    // Both requesters write continuously: grants alternate.
    cycle(); set_req(0, 1, 1, 0, 2, 32'hA0); set_req(1, 1, 1, 0, 3, 32'hB0); #1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin cycle(); #1; end
      chk("t3_ready", bus.req_ready, (k % 2 == 1) ? 2'b00 : ((k % 4 == 0) ? 2'b01 : 2'b10));
      chk("t3_strobes", {bus.avm_write, bus.avm_read}, (k % 2 == 1) ? 2'b10 : 2'b00);
    end
    cycle(); clear_reqs(); #1;
    chk("t3_last_rsp", bus.rsp_valid, 2'b10);
    cycle();

    // Locked pair of writes from requester 0 while requester 1 waits.
    cycle(); set_req(0, 1, 1, 1, 1, 32'h11); set_req(1, 1, 1, 0, 1, 32'h22); #1;
    chk("t4_ready0", bus.req_ready, 2'b01);
    cycle(); set_req(0, 1, 1, 1, 1, 32'h33); #1;
    chk("t4_ready1", bus.req_ready, 2'b00);
    chk("t4_wdata1", bus.avm_writedata, 32'h11);
    cycle(); #1;
    chk("t4_ready2", bus.req_ready, 2'b01);
    chk("t4_rsp1", bus.rsp_valid, 2'b01);
    cycle(); set_req(0, 0, 1, 1, 1, 32'h33); #1;
    chk("t4_ready3", bus.req_ready, 2'b00);
    chk("t4_wdata2", bus.avm_writedata, 32'h33);
    cycle(); bus.req_lock[0] = 1'b0; #1;
    chk("t4_ready4", bus.req_ready, 2'b00);
    chk("t4_rsp2", bus.rsp_valid, 2'b01);
    cycle(); #1;
    chk("t4_ready5", bus.req_ready, 2'b10);
    cycle(); clear_reqs(); #1;
    cycle(); cycle();

    // Lock taken then abandoned: timeout hands the bus to requester 1.
    cycle(); set_req(0, 1, 1, 1, 0, 32'h1); #1;
    chk("t5_ready0", bus.req_ready, 2'b01);
    cycle(); set_req(0, 0, 1, 1, 0, 32'h1); set_req(1, 1, 1, 0, 1, 32'h5); #1;
    got = -1;
    for (int j = 2; j < 120; j++) begin
      cycle(); #1;
      if (bus.req_ready != 0) begin got = j; break; end
    end
    chk("t5_timeout_cycle", got, 2 + LT);
    chk("t5_ready1", bus.req_ready, 2'b10);
    cycle(); clear_reqs(); #1;
    cycle(); cycle();

    // Reset while waiting for read data.
    cycle(); set_req(0, 1, 0, 0, 1, 0); #1;
    chk("t6_ready", bus.req_ready, 2'b01);
    cycle(); clear_reqs(); #1;
    chk("t6_read", bus.avm_read, 1);
    cycle(); reset = 1'b1; #1;
    cycle(); reset = 1'b0; #1;
    chk_all_zero("t6_after_reset");
    cycle(); set_req(0, 1, 1, 0, 2, 32'h77); set_req(1, 1, 1, 0, 3, 32'h88); #1;
    chk("t6_first_grant", bus.req_ready, 2'b01);
    cycle(); clear_reqs(); #1;
    cycle(); #1;
    chk("t6_rsp", bus.rsp_valid, 2'b01);

    // Randomized traffic against a transaction-level model.
    cycle(); reset = 1'b1; clear_reqs();
    cycle();
    for (int i = 0; i < 8; i++) model_mem[i] = DATA_W'(i);
    free_cyc = 0; ptr = 0; st_cyc = -1; rs_cyc = -1; rs_who = 0;
    st_wr = 0; rs_rd = 0; st_addr = '0; st_data = '0; rs_data = '0;
    last_rd = '0; acc_obs = '0;
    for (int c = 0; c < 3000; c++) begin
      cycle();
      reset = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        if (acc_obs[i] || !bus.req_valid[i]) begin
          if ($urandom_range(0, 2) != 0)
            set_req(i, 1, 1'($urandom_range(0, 1)), 0, ADDR_W'($urandom_range(0, 7)), $urandom);
          else
            set_req(i, 0, 0, 0, 0, 0);
        end else if ($urandom_range(0, 15) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      #1;
      chk("rnd_write", bus.avm_write, (c == st_cyc) && st_wr);
      chk("rnd_read", bus.avm_read, (c == st_cyc) && !st_wr);
      if (c == st_cyc) begin
        chk("rnd_addr", bus.avm_address, st_addr);
        if (st_wr) chk("rnd_wdata", bus.avm_writedata, st_data);
      end
      if (c == rs_cyc && rs_rd) last_rd = rs_data;
      chk("rnd_rsp", bus.rsp_valid, (c == rs_cyc) ? (N_REQ'(1) << rs_who) : '0);
      chk("rnd_rdata", bus.rsp_rdata, last_rd);
      exp_rdy = '0;
      if (c >= free_cyc && |bus.req_valid) begin
        w = 0;
        for (int k = N_REQ - 1; k >= 0; k--)
          if (bus.req_valid[(ptr + k) % N_REQ]) w = (ptr + k) % N_REQ;
        exp_rdy[w] = 1'b1;
        ptr     = (w + 1) % N_REQ;
        st_cyc  = c + 1;
        st_wr   = bus.req_write[w];
        st_addr = bus.req_addr[w*ADDR_W +: ADDR_W];
        st_data = bus.req_wdata[w*DATA_W +: DATA_W];
        rs_cyc  = st_wr ? c + 2 : c + 2 + RL;
        rs_who  = w;
        rs_rd   = !st_wr;
        if (st_wr) model_mem[st_addr] = st_data;
        else       rs_data = model_mem[st_addr];
        free_cyc = rs_cyc;
      end
      chk("rnd_ready", bus.req_ready, exp_rdy);
      acc_obs = bus.req_ready;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
